// File: rtl/wb8_bus_pkg.sv
// Shared types and helpers for the Wishbone-8 bus decoder.
// No logic of its own: state encoding, error-completion data, window match.
// Backpressure: not applicable.
package wb8_bus_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Read data returned to the master on a timeout completion
   localparam logic [7:0] WB8_ERR_DATA = 8'h00;

   // A zero mask disables the window entirely so unused slots never match
   function automatic logic slave_match(input logic [31:0] adr,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
      return (mask != 32'h0) && ((adr & mask) == (base & mask));
   endfunction

endpackage

// File: rtl/wb8_addr_match.sv
// Priority address decoder: lowest-index matching base/mask window wins.
// Latency: purely combinational, zero cycles.
// Backpressure: none, it only produces a select index and hit flag.
module wb8_addr_match
   import wb8_bus_pkg::*;
#(
   parameter int NSLAVES = 8,
   parameter int SW      = 3
)(
   input  logic [31:0]           i_adr,
   input  logic [32*NSLAVES-1:0] i_bases,
   input  logic [32*NSLAVES-1:0] i_masks,
   output logic [SW-1:0]         o_sel,
   output logic                  o_hit
);

   // Scan from the top index down so the lowest matching index is the last write
   always_comb begin
      o_sel = '0;
      o_hit = 1'b0;
      for (int i = NSLAVES - 1; i >= 0; i--) begin
         if (slave_match(i_adr, i_bases[32*i +: 32], i_masks[32*i +: 32])) begin
            o_sel = SW'(i);
            o_hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb8_bus_decoder.sv
// Wishbone-8 CPU-to-slaves interconnect with window decode, select latch and timeout watchdog.
// Latency: zero added cycles (stb and ack pass straight through); timeout ack TIMEOUT+1 cycles after first stb.
// Backpressure: selected slave's stall is forwarded to the master; a dropped stb aborts the access.
module wb8_bus_decoder
   import wb8_bus_pkg::*;
#(
   parameter int                    NSLAVES       = 8,
   parameter logic [32*NSLAVES-1:0] ADR_BASES     = '0,
   parameter logic [32*NSLAVES-1:0] ADR_MASKS     = '0,
   parameter int                    DEFAULT_SLAVE = NSLAVES - 1,
   parameter int                    TIMEOUT       = 255
)(
   input  logic                 I_wb_clk,
   input  logic                 I_reset,
   input  logic [31:0]          I_wb_adr,
   input  logic                 I_wb_stb,
   input  logic                 I_wb_we,
   output logic [7:0]           O_wb_dat,
   output logic                 O_wb_ack,
   output logic                 O_wb_stall,
   output logic [NSLAVES-1:0]   O_slv_stb,
   input  logic [8*NSLAVES-1:0] I_slv_dat,
   input  logic [NSLAVES-1:0]   I_slv_ack,
   input  logic [NSLAVES-1:0]   I_slv_stall,
   input  logic                 I_err_clr,
   output logic                 O_err,
   output logic [31:0]          O_err_adr,
   output logic                 O_err_we,
   output logic [7:0]           O_err_cnt
);

   localparam int            SW      = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
   localparam int            CW      = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0] DEF_SEL = SW'(DEFAULT_SLAVE);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

   state_t        r_state;
   state_t        w_next_state;
   logic [SW-1:0] r_sel;
   logic [31:0]   r_adr;
   logic          r_we;
   logic [CW-1:0] r_cnt;
   logic          r_err;
   logic [31:0]   r_err_adr;
   logic          r_err_we;
   logic [7:0]    r_err_cnt;

   logic [SW-1:0] w_match_sel;
   logic          w_match_hit;
   logic [SW-1:0] w_dec_sel;
   logic [SW-1:0] w_sel;
   logic          w_sel_ack;
   logic [7:0]    w_sel_dat;
   logic          w_start;
   logic          w_cnt_inc;
   logic          w_err_set;

   wb8_addr_match #(
      .NSLAVES (NSLAVES),
      .SW      (SW)
   ) u_match (
      .i_adr   (I_wb_adr),
      .i_bases (ADR_BASES),
      .i_masks (ADR_MASKS),
      .o_sel   (w_match_sel),
      .o_hit   (w_match_hit)
   );

   // Live decode in IDLE; once an access is outstanding the latched select owns the bus
   always_comb begin
      w_dec_sel = w_match_hit ? w_match_sel : DEF_SEL;
      w_sel     = (r_state == BUSY) ? r_sel : w_dec_sel;
      w_sel_ack = I_slv_ack[w_sel];
      w_sel_dat = I_slv_dat[{w_sel, 3'b000} +: 8];
   end

   // Next state and bus outputs; acks are only honoured while the master strobes
   always_comb begin
      w_next_state = r_state;
      O_slv_stb    = '0;
      O_wb_ack     = 1'b0;
      O_wb_dat     = w_sel_dat;
      O_wb_stall   = I_slv_stall[w_sel];
      w_start      = 1'b0;
      w_cnt_inc    = 1'b0;
      w_err_set    = 1'b0;
      case (r_state)
         IDLE: begin
            O_slv_stb[w_sel] = I_wb_stb;
            O_wb_ack         = I_wb_stb & w_sel_ack;
            if (I_wb_stb && !w_sel_ack) begin
               w_start      = 1'b1;
               w_next_state = BUSY;
            end
         end
         BUSY: begin
            if (!I_wb_stb) begin
               w_next_state = IDLE;
            end else if (w_sel_ack) begin
               O_slv_stb[w_sel] = 1'b1;
               O_wb_ack         = 1'b1;
               w_next_state     = IDLE;
            end else if (r_cnt == CNT_MAX) begin
               O_wb_ack     = 1'b1;
               O_wb_dat     = WB8_ERR_DATA;
               w_err_set    = 1'b1;
               w_next_state = IDLE;
            end else begin
               O_slv_stb[w_sel] = 1'b1;
               w_cnt_inc        = 1'b1;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // State, latched access context and watchdog counter
   always_ff @(posedge I_wb_clk) begin
      if (I_reset) begin
         r_state <= IDLE;
         r_sel   <= DEF_SEL;
         r_adr   <= '0;
         r_we    <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_start) begin
            r_sel <= w_dec_sel;
            r_adr <= I_wb_adr;
            r_we  <= I_wb_we;
            r_cnt <= '0;
         end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   // Sticky error record; a timeout in the same cycle as a clear leaves a fresh count of one
   always_ff @(posedge I_wb_clk) begin
      if (I_reset) begin
         r_err     <= 1'b0;
         r_err_adr <= '0;
         r_err_we  <= 1'b0;
         r_err_cnt <= '0;
      end else if (w_err_set) begin
         r_err     <= 1'b1;
         r_err_adr <= r_adr;
         r_err_we  <= r_we;
         if (I_err_clr) begin
            r_err_cnt <= 8'd1;
         end else if (r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
      end else if (I_err_clr) begin
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end
   end

   assign O_err     = r_err;
   assign O_err_adr = r_err_adr;
   assign O_err_we  = r_err_we;
   assign O_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_wb8_bus_decoder.sv
// Self-checking bench for wb8_bus_decoder (4 slaves, TIMEOUT 16).
// Latency: checks outputs on the falling edge, advances a transaction-level model on the rising edge.
// Backpressure: stall forwarding and master aborts exercised by directed and random stimulus.
module tb_wb8_bus_decoder;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst, stb, we, clr;
   logic [31:0] adr;
   logic [3:0]  sack, sstall;
   logic [31:0] sdat;

   logic [7:0]  wdat, ov_wdat;
   logic        wack, wstall, ov_wack, ov_wstall;
   logic [3:0]  sstb, ov_sstb;
   logic        err, errwe, ov_err, ov_errwe;
   logic [31:0] erradr, ov_erradr;
   logic [7:0]  errcnt, ov_errcnt;

   int checks = 0;
   int errors = 0;

   // Snapshot of outputs taken on the falling edge of the last step
   logic [3:0] s_stb, s_stb_ov;
   logic       s_ack, s_stall;
   logic [7:0] s_dat;

   // Reference model state: outstanding access and error record
   bit          m_busy;
   int          m_sel, m_age;
   logic [31:0] m_adr;
   logic        m_we, m_err, m_err_we;
   logic [31:0] m_err_adr;
   logic [7:0]  m_err_cnt;

   typedef struct {
      logic [31:0] adr;
      logic        stb;
      logic [3:0]  exp_stb;
      logic [3:0]  exp_ov;
      logic        exp_ack;
      logic [7:0]  exp_dat;
   } vec_t;
   vec_t vecs [9];

   always #5 clk = ~clk;

   wb8_bus_decoder #(
      .NSLAVES(4),
      .ADR_BASES({32'h0, 32'hFFFFFFF0, 32'hFFFFF800, 32'hFFFFF000}),
      .ADR_MASKS({32'h0, 32'hFFFFFFF0, 32'hFFFFFF00, 32'hFFFFF800}),
      .DEFAULT_SLAVE(3), .TIMEOUT(TO)
   ) u_dut (
      .I_wb_clk(clk), .I_reset(rst), .I_wb_adr(adr), .I_wb_stb(stb), .I_wb_we(we),
      .O_wb_dat(wdat), .O_wb_ack(wack), .O_wb_stall(wstall), .O_slv_stb(sstb),
      .I_slv_dat(sdat), .I_slv_ack(sack), .I_slv_stall(sstall), .I_err_clr(clr),
      .O_err(err), .O_err_adr(erradr), .O_err_we(errwe), .O_err_cnt(errcnt)
   );

   // Overlapping windows: slave 1 covers everything slave 0 covers
   wb8_bus_decoder #(
      .NSLAVES(4),
      .ADR_BASES({32'h0, 32'hFFFFFFF0, 32'hFFFFF000, 32'hFFFFF000}),
      .ADR_MASKS({32'h0, 32'hFFFFFFF0, 32'hFFFFF000, 32'hFFFFF800}),
      .DEFAULT_SLAVE(3), .TIMEOUT(TO)
   ) u_dut_ov (
      .I_wb_clk(clk), .I_reset(rst), .I_wb_adr(adr), .I_wb_stb(stb), .I_wb_we(we),
      .O_wb_dat(ov_wdat), .O_wb_ack(ov_wack), .O_wb_stall(ov_wstall), .O_slv_stb(ov_sstb),
      .I_slv_dat(sdat), .I_slv_ack(sack), .I_slv_stall(sstall), .I_err_clr(clr),
      .O_err(ov_err), .O_err_adr(ov_erradr), .O_err_we(ov_errwe), .O_err_cnt(ov_errcnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int ref_decode(input logic [31:0] a);
      logic [31:0] b [4];
      logic [31:0] m [4];
      b = '{32'hFFFFF000, 32'hFFFFF800, 32'hFFFFFFF0, 32'h0};
      m = '{32'hFFFFF800, 32'hFFFFFF00, 32'hFFFFFFF0, 32'h0};
      for (int i = 0; i < 4; i++)
         if (m[i] != 0 && (a & m[i]) == (b[i] & m[i])) return i;
      return 3;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_sel = 3; m_age = 0; m_adr = '0; m_we = 0;
      m_err = 0; m_err_adr = '0; m_err_we = 0; m_err_cnt = '0;
   endtask

   // One bus cycle: compare against the model at negedge, advance the model at posedge
   task automatic step();
      int         s;
      logic [3:0] e_stb;
      logic       e_ack, e_ev;
      logic [7:0] e_dat;
      @(negedge clk);
      s_stb = sstb; s_stb_ov = ov_sstb; s_ack = wack; s_dat = wdat; s_stall = wstall;
      s = m_busy ? m_sel : ref_decode(adr);
      e_stb = '0; e_ack = 0; e_ev = 0; e_dat = sdat[8*s +: 8];
      if (!m_busy) begin
         if (stb) begin e_stb[s] = 1'b1; e_ack = sack[s]; end
      end else if (stb) begin
         if (sack[s]) begin e_stb[s] = 1'b1; e_ack = 1; end
         else if (m_age == TO + 1) begin e_ack = 1; e_dat = 8'h00; e_ev = 1; end
         else e_stb[s] = 1'b1;
      end
      chk("m_slv_stb", s_stb, e_stb);
      chk("m_ack", s_ack, e_ack);
      if (e_ack) chk("m_dat", s_dat, e_dat);
      chk("m_stall", s_stall, sstall[s]);
      chk("m_err", err, m_err);
      chk("m_err_adr", erradr, m_err_adr);
      chk("m_err_we", errwe, m_err_we);
      chk("m_err_cnt", errcnt, m_err_cnt);
      @(posedge clk);
      if (rst) model_reset();
      else begin
         if (e_ev) begin
            m_err = 1; m_err_adr = m_adr; m_err_we = m_we;
            m_err_cnt = clr ? 8'd1 : (m_err_cnt == 8'hFF ? 8'hFF : m_err_cnt + 8'd1);
         end else if (clr) begin
            m_err = 0; m_err_cnt = 0;
         end
         if (!m_busy) begin
            if (stb && !sack[s]) begin
               m_busy = 1; m_sel = s; m_adr = adr; m_we = we; m_age = 1;
            end
         end else if (!stb || e_ack) m_busy = 0;
         else m_age++;
      end
      #1;
   endtask

   // Run a full timeout on the given address, pulsing clr on the error-ack cycle if asked
   task automatic run_timeout(input logic [31:0] a, input logic w, input logic clr_at_err, input string tag);
      adr = a; we = w; stb = 1; sack = 0;
      for (int k = 0; k <= TO + 1; k++) begin
         clr = clr_at_err && (k == TO + 1);
         step();
         chk({tag, "_ack"}, s_ack, k == TO + 1);
      end
      clr = 0; stb = 0; we = 0;
   endtask

   initial begin
      vecs[0] = '{32'hFFFFF004, 1'b1, 4'b0001, 4'b0001, 1'b1, 8'h5A};
      vecs[1] = '{32'hFFFFF010, 1'b1, 4'b0001, 4'b0001, 1'b1, 8'h5A};
      vecs[2] = '{32'hFFFFF7FF, 1'b1, 4'b0001, 4'b0001, 1'b1, 8'h5A};
      vecs[3] = '{32'hFFFFF8AB, 1'b1, 4'b0010, 4'b0010, 1'b1, 8'hA5};
      vecs[4] = '{32'hFFFFFFF4, 1'b1, 4'b0100, 4'b0010, 1'b1, 8'h3C};
      vecs[5] = '{32'hFFFFFFF0, 1'b1, 4'b0100, 4'b0010, 1'b1, 8'h3C};
      vecs[6] = '{32'hFFFFF900, 1'b1, 4'b1000, 4'b0010, 1'b1, 8'h11};
      vecs[7] = '{32'h00001234, 1'b1, 4'b1000, 4'b1000, 1'b1, 8'h11};
      vecs[8] = '{32'hFFFFF004, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00};

      rst = 1; stb = 0; we = 0; clr = 0; adr = '0; sack = 4'hF; sstall = 0;
      sdat = {8'h11, 8'h3C, 8'hA5, 8'h5A};
      repeat (3) @(posedge clk);
      #1 rst = 0;
      model_reset();

      // Reset state
      chk("rst_err", err, 0);
      chk("rst_err_adr", erradr, 0);
      chk("rst_err_we", errwe, 0);
      chk("rst_err_cnt", errcnt, 0);
      chk("rst_slv_stb", sstb, 0);
      chk("rst_ack_ignored", wack, 0);

      // Table: single-cycle accesses, every slave acks so both instances stay idle
      for (int v = 0; v < 9; v++) begin
         adr = vecs[v].adr; stb = vecs[v].stb; sack = 4'hF;
         step();
         chk($sformatf("vec%0d_stb", v), s_stb, vecs[v].exp_stb);
         chk($sformatf("vec%0d_ov_stb", v), s_stb_ov, vecs[v].exp_ov);
         chk($sformatf("vec%0d_ack", v), s_ack, vecs[v].exp_ack);
         if (vecs[v].exp_ack) chk($sformatf("vec%0d_dat", v), s_dat, vecs[v].exp_dat);
      end
      stb = 0; sack = 0; step();

      // Slave 0 acks one cycle late
      adr = 32'hFFFFF004; stb = 1; step();
      chk("A_c0_stb", s_stb, 4'b0001);
      chk("A_c0_ack", s_ack, 0);
      sack = 4'b0001; step();
      chk("A_c1_stb", s_stb, 4'b0001);
      chk("A_c1_ack", s_ack, 1);
      chk("A_c1_dat", s_dat, 8'h5A);
      stb = 0; sack = 0; step();
      chk("A_no_err", err, 0);

      // Same-cycle ack, then a different slave next cycle proves the FSM stayed idle
      adr = 32'h00001234; stb = 1; sack = 4'b1000; step();
      chk("B_stb", s_stb, 4'b1000);
      chk("B_ack", s_ack, 1);
      chk("B_dat", s_dat, 8'h11);
      adr = 32'hFFFFFFF4; sack = 4'b0100; step();
      chk("B_idle_stb", s_stb, 4'b0100);
      stb = 0; sack = 0; step();

      // Write timeout on slave 2; address moves mid-access; late ack ignored
      adr = 32'hFFFFFFF4; we = 1; stb = 1; sack = 0;
      for (int k = 0; k <= TO + 1; k++) begin
         if (k == 5) adr = 32'h00001234;
         step();
         chk("C_ack", s_ack, k == TO + 1);
         if (k > 0 && k <= TO) chk("C_stb_latched", s_stb, 4'b0100);
         if (k == TO + 1) begin
            chk("C_err_dat", s_dat, 8'h00);
            chk("C_err_stb", s_stb, 4'b0000);
         end
         if (k >= TO) chk("C_err_edge", err, k == TO + 1);
      end
      stb = 0; we = 0;
      for (int k = TO + 2; k <= 20; k++) begin
         sack = (k == 20) ? 4'b0100 : 4'b0000;
         step();
         chk("C_late_ack", s_ack, 0);
      end
      sack = 0;
      chk("C_err", err, 1);
      chk("C_err_adr", erradr, 32'hFFFFFFF4);
      chk("C_err_we", errwe, 1);
      chk("C_err_cnt", errcnt, 1);

      // Stalling slave 3 still times out; then clear the error record
      adr = 32'h00001234; stb = 1; sstall = 4'b1000;
      for (int k = 0; k <= 20; k++) begin
         if (k == TO + 2) stb = 0;
         sack = (k == 20) ? 4'b1000 : 4'b0000;
         step();
         if (k <= TO) chk("D_stall", s_stall, 1);
         chk("D_ack", s_ack, k == TO + 1);
      end
      sack = 0; sstall = 0;
      chk("D_err_cnt", errcnt, 2);
      chk("D_err_we", errwe, 0);
      clr = 1; step(); clr = 0;
      chk("D_clr_err", err, 0);
      chk("D_clr_cnt", errcnt, 0);

      // Timeout and clear in the same cycle: error wins with a count of one
      run_timeout(32'hFFFFFFF4, 1'b0, 1'b1, "E");
      chk("E_err", err, 1);
      chk("E_err_cnt", errcnt, 1);

      // Slave ack on the timeout cycle wins over the error
      adr = 32'hFFFFF8AB; stb = 1;
      for (int k = 0; k <= TO + 1; k++) begin
         sack = (k == TO + 1) ? 4'b0010 : 4'b0000;
         step();
         chk("F_ack", s_ack, k == TO + 1);
         if (k == TO + 1) chk("F_dat", s_dat, 8'hA5);
      end
      stb = 0; sack = 0; step();
      chk("F_err_cnt", errcnt, 1);

      // Reset at BUSY cycle 5
      adr = 32'hFFFFFFF4; stb = 1;
      for (int k = 0; k < 5; k++) step();
      rst = 1; stb = 0; step();
      chk("G_no_ack", s_ack, 0);
      rst = 0;
      chk("G_err", err, 0);
      chk("G_err_adr", erradr, 0);
      chk("G_err_we", errwe, 0);
      chk("G_err_cnt", errcnt, 0);
      adr = 32'h00001234; stb = 1; sack = 4'b1000; step();
      chk("G_idle_stb", s_stb, 4'b1000);
      chk("G_idle_ack", s_ack, 1);
      stb = 0; sack = 0; step();

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 399) == 0);
         stb = stb ? ($urandom_range(0, 31) != 0) : ($urandom_range(0, 1) == 1);
         we  = 1'($urandom_range(0, 1));
         clr = ($urandom_range(0, 63) == 0);
         case ($urandom_range(0, 4))
            0: adr = 32'hFFFFF004;
            1: adr = 32'hFFFFF8AB;
            2: adr = 32'hFFFFFFF4;
            3: adr = 32'h00001234;
            default: adr = $urandom();
         endcase
         for (int i = 0; i < 4; i++) sack[i] = ($urandom_range(0, 11) == 0);
         sstall = 4'($urandom_range(0, 15));
         sdat = $urandom();
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
